// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store engine: size codes, FSM
// encoding and the store-lane / load-extension helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Code 3 is reserved and behaves as a word everywhere.
  function automatic logic [31:0] replicate_store(input logic [1:0] size,
                                                  input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: replicate_store = {4{wdata[7:0]}};
      SIZE_HALF: replicate_store = {2{wdata[15:0]}};
      default:   replicate_store = wdata;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [1:0]  size,
                                              input logic        zero_ext);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: extend_load = {{24{~zero_ext & lane_b[7]}}, lane_b};
      SIZE_HALF: extend_load = {{16{~zero_ext & lane_h[15]}}, lane_h};
      default:   extend_load = word;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] load_data
);

  assign load_data = extend_load(rdata, addr_lo, size, zero_ext);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs the held EX/MEM op over an address/data
// handshake bus, stalls EX/MEM while in flight and flags misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        data_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        adel,
  output logic        ades,
  output state_t      state
);

  // Bus handshake: a request is held in REQ until data_addr_ok; the matching
  // data_data_ok arrives at the earliest one cycle later. The request may be
  // withdrawn before acceptance, but an accepted one must be drained.

  logic        misaligned;
  logic        aligned_op;
  logic        in_req;
  logic [31:0] rdata_q;

  assign misaligned = ((op_size == SIZE_HALF) && op_addr[0]) ||
                      (op_size[1] && (op_addr[1:0] != 2'b00));
  assign aligned_op = (op_load || op_store) && !misaligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE:  if (aligned_op && !exception) state <= ST_REQ;
        ST_REQ: begin
          if (exception)         state <= data_addr_ok ? ST_DRAIN : ST_IDLE;
          else if (data_addr_ok) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            if (exception) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DONE;
              rdata_q <= data_rdata;
            end
          end else if (exception) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_DRAIN: if (data_data_ok) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from state and the op held stable by the stall.
  assign in_req     = (state == ST_REQ);
  assign data_req   = in_req;
  assign data_wr    = in_req && op_store;
  assign data_size  = in_req ? op_size : 2'd0;
  assign data_addr  = in_req ? op_addr : 32'd0;
  assign data_wdata = in_req ? replicate_store(op_size, op_wdata) : 32'd0;

  // Gated by reset so every output reads zero while reset is held.
  assign data_stall = rst && aligned_op && !exception && (state != ST_DONE);
  assign adel       = rst && misaligned && op_load;
  assign ades       = rst && misaligned && op_store;
  assign load_valid = (state == ST_DONE) && op_load;

  load_align u_load_align (
    .rdata     (rdata_q),
    .addr_lo   (op_addr[1:0]),
    .size      (op_size),
    .zero_ext  (op_unsigned),
    .load_data (load_data)
  );

endmodule
